// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle HI/LO multiply/divide unit (mult, multu, div, divu,
//            mthi, mtlo). Optional multiply-accumulate ops (madd, maddu,
//            msub, msubu) are compiled in when MULDIV_MADD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] C_OP_MULT  = 4'd0;
  localparam logic [3:0] C_OP_MULTU = 4'd1;
  localparam logic [3:0] C_OP_DIV   = 4'd2;
  localparam logic [3:0] C_OP_DIVU  = 4'd3;
  localparam logic [3:0] C_OP_MTHI  = 4'd4;
  localparam logic [3:0] C_OP_MTLO  = 4'd5;
  localparam logic [3:0] C_OP_MADD  = 4'd6;
  localparam logic [3:0] C_OP_MADDU = 4'd7;
  localparam logic [3:0] C_OP_MSUB  = 4'd8;
  localparam logic [3:0] C_OP_MSUBU = 4'd9;

  localparam logic [7:0] C_MULT_N = MULT_CYCLES[7:0];
  localparam logic [7:0] C_DIV_N  = DIV_CYCLES[7:0];
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             done_q;

  logic             w_finish, w_op_legal, w_madd_legal, w_accept;
  logic             w_mul_signed, w_div_signed;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  logic [WIDTH-1:0] w_dvd, w_dvs, w_dvs_nz, w_quo_mag, w_rem_mag, w_quo, w_rem;
  logic             w_res_wr;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  // The last busy cycle: the counter has one cycle left.
  assign w_finish = (state_q == S_BUSY) && (cnt_q == 8'd1);

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] w_acc_add, w_acc_sub;
  assign w_madd_legal = (op >= C_OP_MADD) && (op <= C_OP_MSUBU);
  // Accumulate uses HI/LO as they stand at the completing edge.
  assign w_acc_add = {hi_q, lo_q} + w_prod;
  assign w_acc_sub = {hi_q, lo_q} - w_prod;
`else
  assign w_madd_legal = 1'b0;
`endif

  assign w_op_legal = (op <= C_OP_MTLO) || w_madd_legal;
  // A new request may also be taken on the completing edge, so back-to-back
  // operations run without an idle cycle.
  assign w_accept   = start && w_op_legal && ((state_q == S_IDLE) || w_finish);

  // One shared multiplier; signed ops sign-extend into the double-width operands.
  assign w_mul_signed = (op_q == C_OP_MULT) || (op_q == C_OP_MADD) || (op_q == C_OP_MSUB);
  assign w_mul_a = w_mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign w_mul_b = w_mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign w_prod  = w_mul_a * w_mul_b;

  // One shared unsigned divider on magnitudes. The most-negative dividend
  // negates to itself, which read unsigned is the correct magnitude, so the
  // most-negative / -1 case needs no special handling.
  assign w_div_signed = (op_q == C_OP_DIV);
  assign w_dvd     = (w_div_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign w_dvs     = (w_div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign w_dvs_nz  = (w_dvs == '0) ? C_ONE : w_dvs;
  assign w_quo_mag = w_dvd / w_dvs_nz;
  assign w_rem_mag = w_dvd % w_dvs_nz;
  assign w_quo = (w_div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -w_quo_mag : w_quo_mag;
  assign w_rem = (w_div_signed && a_q[WIDTH-1]) ? -w_rem_mag : w_rem_mag;

  // Select the HI/LO value written when the in-flight operation completes.
  always_comb begin
    w_res_wr = 1'b1;
    w_res_hi = hi_q;
    w_res_lo = lo_q;
    case (op_q)
      C_OP_MULT, C_OP_MULTU: {w_res_hi, w_res_lo} = w_prod;
      C_OP_DIV, C_OP_DIVU: begin
        if (b_q == '0) begin
          w_res_wr = 1'b0;
        end else begin
          w_res_hi = w_rem;
          w_res_lo = w_quo;
        end
      end
`ifdef MULDIV_MADD_EN
      C_OP_MADD, C_OP_MADDU: {w_res_hi, w_res_lo} = w_acc_add;
      C_OP_MSUB, C_OP_MSUBU: {w_res_hi, w_res_lo} = w_acc_sub;
`endif
      default: w_res_wr = 1'b0;
    endcase
  end

  // Control FSM, cycle counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_finish) begin
        if (w_res_wr) begin
          hi_q <= w_res_hi;
          lo_q <= w_res_lo;
        end
        done_q  <= 1'b1;
        state_q <= S_IDLE;
        cnt_q   <= 8'd0;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - 8'd1;
      end

      if (w_accept) begin
        if (op == C_OP_MTHI) begin
          hi_q <= a;
        end else if (op == C_OP_MTLO) begin
          lo_q <= a;
        end else begin
          op_q    <= op;
          a_q     <= a;
          b_q     <= b;
          state_q <= S_BUSY;
          cnt_q   <= ((op == C_OP_DIV) || (op == C_OP_DIVU)) ? C_DIV_N : C_MULT_N;
        end
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == S_BUSY);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit (WIDTH 32, MULT_CYCLES 5,
//            DIV_CYCLES 10). Build with or without MULDIV_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [3:0] o);
`ifdef MULDIV_MADD_EN
    return (o <= 4'd9);
`else
    return (o <= 4'd5);
`endif
  endfunction

  function automatic void model_calc(input logic [3:0] o, input logic [31:0] x, y, h, l,
                                     output bit wr, output logic [63:0] hl);
    longint sx, sy, q, r, p;
    logic [63:0] ux, uy, pv;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    wr = 1'b1;
    hl = {h, l};
    case (o)
      4'd0: hl = sx * sy;
      4'd1: hl = ux * uy;
      4'd2: if (y == 0) wr = 1'b0;
            else begin q = sx / sy; r = sx % sy; hl = {r[31:0], q[31:0]}; end
      4'd3: if (y == 0) wr = 1'b0;
            else hl = {x % y, x / y};
      4'd6, 4'd8: begin p = sx * sy; pv = p; hl = (o == 4'd6) ? ({h, l} + pv) : ({h, l} - pv); end
      4'd7: hl = {h, l} + ux * uy;
      4'd9: hl = {h, l} - ux * uy;
      default: wr = 1'b0;
    endcase
  endfunction

  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [3:0]  m_op = 0;
  bit          m_pend = 0, m_done = 0;
  int          m_due = 0;

  // Compare DUT against the model each cycle, then predict the next edge.
  initial begin : model_and_compare
    int k;
    bit wr, fin;
    logic [63:0] hl;
    k = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_hi", {32'd0, hi}, {32'd0, m_hi});
        check("model_lo", {32'd0, lo}, {32'd0, m_lo});
        check("model_busy", {63'd0, busy}, {63'd0, m_pend});
        check("model_done", {63'd0, done}, {63'd0, m_done});
      end
      k++;
      if (reset) begin
        m_hi = 0; m_lo = 0; m_pend = 0; m_done = 0;
      end else begin
        fin = m_pend && (k == m_due);
        m_done = 1'b0;
        if (fin) begin
          model_calc(m_op, m_a, m_b, m_hi, m_lo, wr, hl);
          if (wr) {m_hi, m_lo} = hl;
          m_done = 1'b1;
          m_pend = 1'b0;
        end
        if (start && legal(op) && !m_pend) begin
          if (op == 4'd4) m_hi = a;
          else if (op == 4'd5) m_lo = a;
          else begin
            m_pend = 1'b1; m_op = op; m_a = a; m_b = b;
            m_due = k + (((op == 4'd2) || (op == 4'd3)) ? 10 : 5);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x, y,
                        input int n, input logic [31:0] ph, pl, eh, el);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < n; i++) begin
      check({nm, "_busy"}, {63'd0, busy}, 64'd1);
      check({nm, "_hold_hi"}, {32'd0, hi}, {32'd0, ph});
      check({nm, "_hold_lo"}, {32'd0, lo}, {32'd0, pl});
      if (i < n - 1) step();
    end
    step();
    check({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
    check({nm, "_done"}, {63'd0, done}, 64'd1);
    check({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
    step();
    check({nm, "_done_off"}, {63'd0, done}, 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] ph0, pl0;
    repeat (2) step();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    run_op("mult", 4'd0, 32'hFFFFFFFE, 32'd3, 5, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("div", 4'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFA,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 4'd3, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'hFFFFFFFF, 32'hFFFFFFFD);

    // mtlo held during busy is ignored; divu presented at E_N chains directly.
    op = 4'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    op = 4'd5; a = 32'h55;
    repeat (3) step();
    check("mtlo_busy_lo", {32'd0, lo}, {32'd0, 32'hFFFFFFFD});
    start = 1'b0;
    step();
    op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done", {63'd0, done}, 64'd1);
    check("b2b_hi", {32'd0, hi}, 64'd0);
    check("b2b_lo", {32'd0, lo}, 64'd15);
    repeat (9) step();
    check("b2b_busy_late", {63'd0, busy}, 64'd1);
    step();
    check("b2b_div_done", {63'd0, done}, 64'd1);
    check("b2b_div_hi", {32'd0, hi}, 64'd2);
    check("b2b_div_lo", {32'd0, lo}, 64'd14);
    step();

    op = 4'd4; a = 32'h1234; start = 1'b1;
    step();
    start = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h1234);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    check("mthi_done", {63'd0, done}, 64'd0);

    // Reset in the third busy cycle aborts the multiply.
    op = 4'd0; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", {63'd0, done}, 64'd0);
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1; op = 4'd4; a = 32'hABCD; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check("rst_prio_hi", {32'd0, hi}, 64'd0);

    op = 4'd5; a = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'hFFFFFFFF);
`ifdef MULDIV_MADD_EN
    run_op("maddu", 4'd7, 32'd1, 32'd1, 5, 0, 32'hFFFFFFFF, 32'd1, 32'd0);
    ph0 = 32'd1; pl0 = 32'd0;
`else
    op = 4'd7; a = 32'd1; b = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("maddu_off_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("maddu_off_done", {63'd0, done}, 64'd0);
    end
    check("maddu_off_hi", {32'd0, hi}, 64'd0);
    check("maddu_off_lo", {32'd0, lo}, 64'hFFFFFFFF);
    ph0 = 32'd0; pl0 = 32'hFFFFFFFF;
`endif
    run_op("divovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, 10, ph0, pl0, 32'd0, 32'h80000000);
    run_op("multu", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, 32'h80000000,
           32'hFFFFFFFE, 32'h00000001);

    op = 4'd12; a = 32'd9; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    check("illegal_busy", {63'd0, busy}, 64'd0);
    step();
    check("illegal_done", {63'd0, done}, 64'd0);
    check("illegal_hi", {32'd0, hi}, 64'hFFFFFFFE);
`ifdef MULDIV_MADD_EN
    run_op("msub", 4'd8, 32'd2, 32'd3, 5, 32'hFFFFFFFE, 32'h00000001,
           32'hFFFFFFFD, 32'hFFFFFFFB);
`endif
    repeat (2) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles for multiply-class ops (legal range 1..255).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for divide ops (legal range 1..255).
REQ-004 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port start input 1: request; sampled on a rising clk edge with op, a, b.
REQ-007 SHALL have port op input 4: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu.
REQ-008 SHALL have ports a and b, input WIDTH each: rs and rt operands.
REQ-009 SHALL have ports hi and lo, output WIDTH each: current HI/LO register values.
REQ-010 SHALL have port busy output 1: an operation is in flight.
REQ-011 SHALL have port done output 1: one-cycle pulse in the cycle after HI/LO take a multi-cycle result.

Function
REQ-012 SHALL accept a request on an edge where start=1, busy=0, reset=0 and op is legal; otherwise the request SHALL be ignored with no state change.
REQ-013 SHALL treat ops 10..15 as illegal, and also ops 6..9 when MULDIV_MADD_EN is undefined.
REQ-014 SHALL latch a, b and op at the accepting edge E0; later changes to the inputs SHALL have no effect on the result.
REQ-015 SHALL, for mthi/mtlo, write a to HI or LO at E0 only; busy and done SHALL stay 0.
REQ-016 SHALL, for multi-cycle ops, hold busy=1 for exactly N cycles after E0 (N=MULT_CYCLES for ops 0,1,6..9; N=DIV_CYCLES for ops 2,3).
REQ-017 SHALL update HI/LO at edge E_N, deassert busy at the same edge, and assert done for exactly the following cycle.
REQ-018 SHALL hold HI/LO unchanged from E0 until E_N.
REQ-019 SHALL accept a new request at edge E_N; its busy period SHALL start immediately with no idle gap.
REQ-020 SHALL compute mult/multu as {HI,LO} = 2*WIDTH-bit signed or unsigned product.
REQ-021 SHALL compute div/divu as LO=quotient, HI=remainder; signed quotient truncates toward zero and remainder takes the dividend's sign.
REQ-022 SHALL, for signed div with a=most-negative and b=-1, produce LO=a and HI=0.
REQ-023 SHALL, for b=0 on div/divu, leave HI/LO unchanged but still run the full busy period and pulse done.
REQ-024 SHALL use a cycle counter of at most 8 bits; the counter SHALL NOT wrap while busy.

Reset
REQ-025 SHALL, when reset=1 at an edge, clear hi, lo, busy, done and the counter to 0, aborting any in-flight operation with no HI/LO write.
REQ-026 SHALL give reset priority over start on the same edge.

Configuration
REQ-027 SHALL compile ops 6..9 only when macro MULDIV_MADD_EN is defined: {HI,LO} = {HI,LO} +/- product (signed for 6 and 8, unsigned for 7 and 9), mod 2^(2*WIDTH), using HI/LO as sampled at E_N.
REQ-028 SHALL omit the accumulate datapath when MULDIV_MADD_EN is undefined; ops 6..9 SHALL then be ignored per REQ-012.

Verification
REQ-029 Bench SHALL cover: reset, then mult with a=0xFFFFFFFE, b=3 (WIDTH 32, MULT_CYCLES 5) -> busy high for 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, then a single done pulse.
REQ-030 Bench SHALL cover: div with a=-7, b=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with a=7, b=0 -> HI/LO unchanged and done pulses.
REQ-031 Bench SHALL cover: start held high during busy with op=mtlo, a=0x55 -> LO unchanged; a back-to-back request at E_N -> busy stays high with no gap.
REQ-032 Bench SHALL cover: mthi with a=0x1234 while idle -> HI=0x1234 on the next cycle, busy=0, done=0.
REQ-033 Bench SHALL cover: reset asserted in the 3rd busy cycle -> hi=lo=0, busy=0 on the next cycle, no done pulse.
REQ-034 Bench SHALL cover: with MULDIV_MADD_EN defined, HI=0, LO=0xFFFFFFFF, then maddu with a=1, b=1 -> HI=1, LO=0; with the macro undefined the same op is ignored.
